// File: rtl/actuator_spi_host.sv
// rtl/actuator_spi_host.sv - SPI initiator for the actuator driver command port
// Optional trigger_out_n wait timeout: define ACT_HOST_TRIG_TIMEOUT_EN
module actuator_spi_host #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CLKS   = 20,
  parameter int LATCH_CLKS = 100,
  parameter int TRIG_CLKS  = 20,
  parameter int TMO_CLKS   = 4096
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic        cmd_past,
  input  logic        cmd_inv,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sclk,
  output logic        ss_n,
  output logic        mosi,
  input  logic        miso,
  output logic        latch_data_n,
  output logic        trigger_in_n,
  input  logic        trigger_out_n
);

  typedef enum logic [3:0] {
    S_IDLE, S_SHIFT1, S_GAP_A, S_LATCH, S_GAP_B,
    S_SHIFT2, S_TRIG, S_WAIT_TRIG, S_DONE
  } state_t;

  localparam logic [1:0]  OP_WR      = 2'b00;
  localparam logic [1:0]  OP_RD      = 2'b01;
  localparam logic [1:0]  OP_TRIG    = 2'b10;
  localparam logic [1:0]  OP_RSV     = 2'b11;
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CLKS - 1);
  localparam logic [15:0] LATCH_LAST = 16'(LATCH_CLKS - 1);
  localparam logic [15:0] TRIG_LAST  = 16'(TRIG_CLKS - 1);

  state_t      state, state_next;
  logic        ready_en;
  logic [1:0]  op_q;
  logic        err_q;
  logic [31:0] shreg;
  logic [15:0] cap;
  logic [15:0] cnt;
  logic [15:0] div_cnt;
  logic [6:0]  half;
  logic        trig_s1, trig_s2, trig_prev;
  logic [31:0] frame;
  logic        accept, in_shift, div_end, shift_end, trig_fall, tmo_hit;

  assign accept    = cmd_valid & cmd_ready;
  assign in_shift  = (state == S_SHIFT1) || (state == S_SHIFT2);
  assign div_end   = (div_cnt == DIV_LAST);
  // half counts sclk half-periods; half 64 is the trailing low phase before ss_n rises
  assign shift_end = in_shift && (half == 7'd64) && div_end;
  assign trig_fall = trig_prev & ~trig_s2;

`ifdef ACT_HOST_TRIG_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CLKS - 1);
  logic [15:0] tmo_cnt;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)                   tmo_cnt <= 16'h0;
    else if (state != S_WAIT_TRIG) tmo_cnt <= 16'h0;
    else                           tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (state == S_WAIT_TRIG) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    frame = 32'h0;
    case (cmd_op)
      OP_WR:   frame = {8'h02, cmd_addr, cmd_wdata};
      OP_RD:   frame = {8'h01, cmd_addr, 16'h0000};
      OP_TRIG: frame = {2'b00, cmd_past, cmd_inv, 4'h8, 24'h0};
      default: frame = 32'h0;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (accept) state_next = (cmd_op == OP_RSV) ? S_DONE : S_SHIFT1;
      S_SHIFT1:    if (shift_end) state_next = S_GAP_A;
      S_GAP_A:     if (cnt == GAP_LAST) state_next = S_LATCH;
      S_LATCH:     if (cnt == LATCH_LAST) state_next = S_GAP_B;
      S_GAP_B: begin
        if (cnt == GAP_LAST) begin
          case (op_q)
            OP_RD:   state_next = S_SHIFT2;
            OP_TRIG: state_next = S_TRIG;
            default: state_next = S_DONE;
          endcase
        end
      end
      S_SHIFT2:    if (shift_end) state_next = S_DONE;
      S_TRIG:      if (cnt == TRIG_LAST) state_next = S_WAIT_TRIG;
      S_WAIT_TRIG: if (trig_fall || tmo_hit) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = ready_en && (state == S_IDLE);
    rsp_valid    = (state == S_DONE);
    rsp_err      = (state == S_DONE) && err_q;
    rsp_rdata    = ((state == S_DONE) && (op_q == OP_RD)) ? cap : 16'h0;
    ss_n         = !in_shift;
    sclk         = in_shift && half[0];
    mosi         = in_shift && shreg[31];
    latch_data_n = (state != S_LATCH);
    trigger_in_n = (state != S_TRIG);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ready_en  <= 1'b0;
      op_q      <= OP_WR;
      err_q     <= 1'b0;
      shreg     <= 32'h0;
      cap       <= 16'h0;
      cnt       <= 16'h0;
      div_cnt   <= 16'h0;
      half      <= 7'd0;
      trig_s1   <= 1'b1;
      trig_s2   <= 1'b1;
      trig_prev <= 1'b1;
    end else begin
      ready_en  <= 1'b1;
      trig_s1   <= trigger_out_n;
      trig_s2   <= trig_s1;
      trig_prev <= trig_s2;

      if (state_next != state) cnt <= 16'h0;
      else                     cnt <= cnt + 16'd1;

      if (accept) begin
        op_q  <= cmd_op;
        err_q <= (cmd_op == OP_RSV);
        shreg <= frame;
      end else if (tmo_hit) begin
        err_q <= 1'b1;
      end else if ((state == S_GAP_B) && (state_next == S_SHIFT2)) begin
        shreg <= 32'h0;
      end else if (in_shift && div_end && half[0]) begin
        shreg <= {shreg[30:0], 1'b0};
      end

      // miso is taken on the clock that raises sclk; only the last 16 bits matter
      if (in_shift && div_end && !half[0] && (half != 7'd64))
        cap <= {cap[14:0], miso};

      if (!in_shift || (state_next != state)) begin
        div_cnt <= 16'h0;
        half    <= 7'd0;
      end else if (div_end) begin
        div_cnt <= 16'h0;
        if (half != 7'd64) half <= half + 7'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_actuator_spi_host.sv
// tb/tb_actuator_spi_host.sv - directed scoreboard bench for actuator_spi_host
module tb_actuator_spi_host;

  localparam logic [31:0] SLAVE_WORD = 32'h0000_000F;

  logic        clock = 1'b0;
  logic        resetb;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_past;
  logic        cmd_inv;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        sclk;
  logic        ss_n;
  logic        mosi;
  logic        miso = 1'b0;
  logic        latch_data_n;
  logic        trigger_in_n;
  logic        trigger_out_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_frames[$];
  logic [16:0] exp_rsp[$];
  logic [31:0] obs_frames[$];
  int          obs_rises[$];
  int          lat_widths[$];
  int          trig_widths[$];
  int          fidx = 0, lidx = 0, tidx = 0;

  logic [31:0] mon_frame = 32'h0;
  logic [31:0] slave_sr  = 32'h0;
  int          mon_rises = 0;
  int          ss_falls  = 0;
  int          lat_run   = 0;
  int          trig_run  = 0;
  int          n_acc     = 0;
  logic        prev_ss   = 1'b1;
  logic        prev_sclk = 1'b0;

  actuator_spi_host #(.CLK_DIV(4), .GAP_CLKS(20), .LATCH_CLKS(100), .TRIG_CLKS(20), .TMO_CLKS(64)) dut (
    .clock(clock), .resetb(resetb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_past(cmd_past), .cmd_inv(cmd_inv),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .latch_data_n(latch_data_n), .trigger_in_n(trigger_in_n), .trigger_out_n(trigger_out_n)
  );

  always #5 clock = ~clock;

  // Pin monitor and slave model, sampled mid-cycle
  always @(negedge clock) begin
    if (prev_ss && !ss_n) begin
      mon_frame = 32'h0;
      mon_rises = 0;
      ss_falls++;
      slave_sr = SLAVE_WORD;
      miso = slave_sr[31];
    end else if (!ss_n && prev_sclk && !sclk) begin
      slave_sr = {slave_sr[30:0], 1'b0};
      miso = slave_sr[31];
    end
    if (!ss_n && sclk && !prev_sclk) begin
      mon_frame = {mon_frame[30:0], mosi};
      mon_rises++;
    end
    if (!prev_ss && ss_n && resetb) begin
      obs_frames.push_back(mon_frame);
      obs_rises.push_back(mon_rises);
    end
    if (!latch_data_n) lat_run++;
    else if (lat_run != 0) begin lat_widths.push_back(lat_run); lat_run = 0; end
    if (!trigger_in_n) trig_run++;
    else if (trig_run != 0) begin trig_widths.push_back(trig_run); trig_run = 0; end
    prev_ss   = ss_n;
    prev_sclk = sclk;
  end

  always @(posedge clock) begin
    if (resetb && cmd_valid && cmd_ready) n_acc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  task automatic check_rsp();
    logic [16:0] e;
    e = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : 17'bx;
    chk("rsp_err_rdata", {15'b0, rsp_err, rsp_rdata}, {15'b0, e});
  endtask

  task automatic wait_rsp(input int budget, output int waited);
    waited = 0;
    while (!rsp_valid && waited < budget) begin
      @(negedge clock);
      waited++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    if (rsp_valid) check_rsp();
  endtask

  task automatic check_frames();
    logic [31:0] e, o;
    int r;
    while (exp_frames.size() > 0) begin
      e = exp_frames.pop_front();
      o = (fidx < obs_frames.size()) ? obs_frames[fidx] : 32'hx;
      r = (fidx < obs_rises.size()) ? obs_rises[fidx] : -1;
      fidx++;
      chk("mosi_frame", o, e);
      chk("sclk_rises", r, 32);
    end
  endtask

  task automatic check_latch();
    int w;
    w = (lidx < lat_widths.size()) ? lat_widths[lidx] : -1;
    lidx++;
    chk("latch_width", w, 100);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wd,
                       input logic past, input logic inv, input bit hold);
    int n;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_past = past; cmd_inv = inv;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
    chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    @(negedge clock);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_trig_pulse();
    int n;
    n = 0;
    while (trigger_in_n && n < 1000) begin @(negedge clock); n++; end
    chk("trig_in_low_seen", 32'(trigger_in_n), 32'd0);
    n = 0;
    while (!trigger_in_n && n < 100) begin @(negedge clock); n++; end
    chk("trig_in_high_again", 32'(trigger_in_n), 32'd1);
  endtask

  initial begin
    int w, f0, a0, n, seen;
    resetb = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_wdata = 16'h0;
    cmd_past = 1'b0; cmd_inv = 1'b0; trigger_out_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_outputs",
        {22'b0, cmd_ready, rsp_valid, rsp_err, sclk, ss_n, mosi, latch_data_n, trigger_in_n, 2'b0},
        {22'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b0});
    chk("reset_rdata", {16'b0, rsp_rdata}, 32'h0);
    resetb = 1'b1;
    #1 chk("ready_before_first_edge", 32'(cmd_ready), 32'd0);
    @(negedge clock);
    chk("ready_after_first_edge", 32'(cmd_ready), 32'd1);

    // Write addr 02 data 0004
    exp_frames.push_back(32'h0202_0004);
    exp_rsp.push_back({1'b0, 16'h0000});
    issue(2'b00, 8'h02, 16'h0004, 1'b0, 1'b0, 1'b0);
    wait_rsp(1000, w);
    @(negedge clock);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check_frames();
    check_latch();

    // Read addr 04 with cmd_valid held throughout
    f0 = ss_falls; a0 = n_acc;
    exp_frames.push_back(32'h0104_0000);
    exp_frames.push_back(32'h0000_0000);
    exp_rsp.push_back({1'b0, 16'h000F});
    issue(2'b01, 8'h04, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    wait_rsp(2000, w);
    cmd_valid = 1'b0;
    @(negedge clock);
    check_frames();
    check_latch();
    chk("read_ss_windows", ss_falls - f0, 32'd2);
    chk("read_single_accept", n_acc - a0, 32'd1);

    // Trigger past=1 inv=0, completion 50 clocks after trigger_in_n returns high
    exp_frames.push_back(32'h2800_0000);
    exp_rsp.push_back({1'b0, 16'h0000});
    issue(2'b10, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0);
    wait_trig_pulse();
    repeat (50) @(negedge clock);
    trigger_out_n = 1'b0;
    wait_rsp(10, w);
    chk("trig_done_within_4", 32'(w <= 4), 32'd1);
    @(negedge clock);
    trigger_out_n = 1'b1;
    check_frames();
    check_latch();
    chk("trig_in_width", (tidx < trig_widths.size()) ? trig_widths[tidx] : -1, 32'd20);
    tidx++;
    repeat (5) @(negedge clock);

    // Reserved op: immediate error response, no SPI activity
    f0 = ss_falls;
    exp_rsp.push_back({1'b1, 16'h0000});
    issue(2'b11, 8'h55, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    wait_rsp(1, w);
    chk("rsv_latency", w, 32'd0);
    @(negedge clock);
    chk("rsv_rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("rsv_no_ss", ss_falls - f0, 32'd0);

    // Reset during bit 10 of a write
    issue(2'b00, 8'h11, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (ss_n && n < 100) begin @(negedge clock); n++; end
    n = 0;
    while (mon_rises < 10 && n < 2000) begin @(negedge clock); n++; end
    chk("reached_bit10", 32'(mon_rises >= 10), 32'd1);
    #2 resetb = 1'b0;
    #1;
    chk("midreset_pins", {28'b0, ss_n, sclk, latch_data_n, rsp_valid}, {28'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    repeat (3) @(negedge clock);
    fidx = obs_frames.size();
    resetb = 1'b1;
    @(negedge clock);
    chk("ready_after_midreset", 32'(cmd_ready), 32'd1);
    exp_frames.push_back(32'h0233_1234);
    exp_rsp.push_back({1'b0, 16'h0000});
    issue(2'b00, 8'h33, 16'h1234, 1'b0, 1'b0, 1'b0);
    wait_rsp(1000, w);
    @(negedge clock);
    check_frames();
    check_latch();

    // Trigger with trigger_out_n never falling
    exp_frames.push_back(32'h1800_0000);
    issue(2'b10, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
    wait_trig_pulse();
`ifdef ACT_HOST_TRIG_TIMEOUT_EN
    exp_rsp.push_back({1'b1, 16'h0000});
    wait_rsp(200, w);
    chk("timeout_clks", w, 32'd64);
    @(negedge clock);
`else
    seen = 0;
    repeat (300) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_without_timeout", seen, 32'd0);
    resetb = 1'b0;
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
`endif
    check_frames();
    chk("rsp_queue_drained", exp_rsp.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
